// File: rtl/div64_if.sv
// Request/response bundle for div64: operands in, quotient/remainder and status out.
// Operands and results are split into 32-bit halves, index 1 = low word, index 2 = high word.
interface div64_if;
  logic        start;
  logic [31:0] N1;
  logic [31:0] N2;
  logic [31:0] D1;
  logic [31:0] D2;
  logic [31:0] Q1;
  logic [31:0] Q2;
  logic [31:0] R1;
  logic [31:0] R2;
  logic        busy;
  logic        done;
  logic        dz;

  modport master (
    output start, N1, N2, D1, D2,
    input  Q1, Q2, R1, R2, busy, done, dz
  );

  modport slave (
    input  start, N1, N2, D1, D2,
    output Q1, Q2, R1, R2, busy, done, dz
  );
endinterface

// File: rtl/div64.sv
// div64: sequential unsigned 64/64 divider resolving one quotient bit per clock
// by restoring shift-subtract; 64 steps from capture to the one-cycle done pulse.
module div64 (
  input  logic   clk,
  input  logic   rst,
  div64_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [63:0] dvd_q, dvd_d;     // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [63:0] dvs_q, dvs_d;
  logic [63:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        zpend_q, zpend_d; // zero-divisor result is published one edge after capture
  logic [63:0] quo_q, quo_d;
  logic [63:0] res_q, res_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic [63:0] numer;
  logic [63:0] denom;
  logic [64:0] rem_shift;
  logic        q_bit;
  logic [63:0] rem_sub;
  logic [63:0] rem_step;
  logic [63:0] quo_step;

  assign numer = {bus.N2, bus.N1};
  assign denom = {bus.D2, bus.D1};

  assign rem_shift = {rem_q, dvd_q[63]};
  assign q_bit     = (rem_shift >= {1'b0, dvs_q});
  // rem_q < divisor, so rem_shift - divisor always fits in 64 bits when taken.
  assign rem_sub   = rem_shift[63:0] - dvs_q;
  assign rem_step  = q_bit ? rem_sub : rem_shift[63:0];
  assign quo_step  = {dvd_q[62:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      zpend_q <= 1'b0;
      quo_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zpend_q <= zpend_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zpend_d = 1'b0;
    quo_d   = quo_q;
    res_d   = res_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (zpend_q) begin
          quo_d  = '1;
          res_d  = dvd_q;
          dz_d   = 1'b1;
          done_d = 1'b1;
        end
        if (bus.start) begin
          dvd_d = numer;
          if (denom != 64'd0) begin
            dvs_d   = denom;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            zpend_d = 1'b1;
          end
        end
      end

      RUN: begin
        dvd_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          quo_d   = quo_step;
          res_d   = rem_step;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.Q1   = quo_q[31:0];
  assign bus.Q2   = quo_q[63:32];
  assign bus.R1   = res_q[31:0];
  assign bus.R2   = res_q[63:32];
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
endmodule

// File: tb/tb_div64.sv
// Self-checking bench for div64: vector table, hand-written corner sequences,
// and a back-to-back random sweep, all scored through an expected-result queue.
`timescale 1ns/1ps
module tb_div64;
  logic clk = 1'b0;
  logic rst;

  div64_if bus ();

  div64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] n;
    logic [63:0] d;
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
  } vec_t;

  localparam int NV = 11;
  localparam int NS = 1000;

  vec_t vt[NV];
  vec_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive_ops(input logic [63:0] n, input logic [63:0] d);
    bus.N1    = n[31:0];
    bus.N2    = n[63:32];
    bus.D1    = d[31:0];
    bus.D2    = d[63:32];
    bus.start = 1'b1;
  endtask

  task automatic issue(input logic [63:0] n, input logic [63:0] d,
                       input logic [63:0] q, input logic [63:0] r, input logic dz);
    vec_t e;
    drive_ops(n, d);
    e.n = n; e.d = d; e.q = q; e.r = r; e.dz = dz;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input int budget, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!bus.done && waited < budget);
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout waited=%0d cycles, required done within %0d", waited, budget);
    end
  endtask

  task automatic check_result(input string tag, output vec_t e);
    logic [63:0] q;
    logic [63:0] r;
    q = {bus.Q2, bus.Q1};
    r = {bus.R2, bus.R1};
    e = '{n: '0, d: '0, q: '0, r: '0, dz: 1'b0};
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected_done got q=%h required no done", tag, q);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_q"}, q, e.q);
      chk({tag, "_r"}, r, e.r);
      chk({tag, "_dz"}, {63'd0, bus.dz}, {63'd0, e.dz});
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    int          w;
    int          nd;
    vec_t        e;
    logic [63:0] n;
    logic [63:0] d;
    logic [127:0] recon;

    vt[0]  = '{n: 64'd12, d: 64'd4, q: 64'd3, r: 64'd0, dz: 1'b0};
    vt[1]  = '{n: '1, d: 64'd1, q: '1, r: 64'd0, dz: 1'b0};
    vt[2]  = '{n: '1, d: '1, q: 64'd1, r: 64'd0, dz: 1'b0};
    vt[3]  = '{n: 64'h0000_0001_0000_0000, d: 64'd3, q: 64'h0000_0000_5555_5555, r: 64'd1, dz: 1'b0};
    vt[4]  = '{n: 64'd7, d: 64'd0, q: '1, r: 64'd7, dz: 1'b1};
    vt[5]  = '{n: 64'd100, d: 64'd7, q: 64'd14, r: 64'd2, dz: 1'b0};
    vt[6]  = '{n: 64'd0, d: 64'd5, q: 64'd0, r: 64'd0, dz: 1'b0};
    vt[7]  = '{n: '1, d: 64'h8000_0000_0000_0001, q: 64'd1, r: 64'h7FFF_FFFF_FFFF_FFFE, dz: 1'b0};
    vt[8]  = '{n: 64'h1234_5678_9ABC_DEF0, d: 64'h0000_0001_0000_0000, q: 64'h0000_0000_1234_5678, r: 64'h0000_0000_9ABC_DEF0, dz: 1'b0};
    vt[9]  = '{n: 64'd5, d: 64'h8000_0000_0000_0000, q: 64'd0, r: 64'd5, dz: 1'b0};
    vt[10] = '{n: 64'd0, d: 64'd0, q: '1, r: 64'd0, dz: 1'b1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.N1 = '0; bus.N2 = '0; bus.D1 = '0; bus.D2 = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_q", {bus.Q2, bus.Q1}, 64'd0);
    chk("reset_r", {bus.R2, bus.R1}, 64'd0);
    chk("reset_flags", {61'd0, bus.busy, bus.done, bus.dz}, 64'd0);
    tick();

    // Vector table: latency, busy behaviour, result and single-cycle done.
    for (int i = 0; i < NV; i++) begin
      issue(vt[i].n, vt[i].d, vt[i].q, vt[i].r, vt[i].dz);
      tick();
      bus.start = 1'b0;
      chk("busy_after_capture", {63'd0, bus.busy}, vt[i].dz ? 64'd0 : 64'd1);
      wait_done(80, w);
      chk("latency", w + 1, vt[i].dz ? 64'd2 : 64'd65);
      if (bus.done) begin
        chk("busy_at_done", {63'd0, bus.busy}, 64'd0);
        check_result("vec", e);
      end
      $display("vec %0d n=%h d=%h q=%h r=%h dz=%0d", i, vt[i].n, vt[i].d,
               {bus.Q2, bus.Q1}, {bus.R2, bus.R1}, bus.dz);
      tick();
      chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
    end

    // start pulsed while running must be ignored.
    issue(64'd100, 64'd7, 64'd14, 64'd2, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    drive_ops(64'd999, 64'd3);
    tick();
    bus.start = 1'b0;
    wait_done(80, w);
    chk("ignore_start_latency", w + 10, 64'd65);
    if (bus.done) check_result("ignore_start", e);
    $display("ignore_start q=%h r=%h", {bus.Q2, bus.Q1}, {bus.R2, bus.R1});
    count_dones(80, nd);
    chk("ignore_start_no_extra_done", nd, 64'd0);

    // Mid-run reset: outputs hold during RUN, then reset discards the division.
    issue(64'd7, 64'd0, '1, 64'd7, 1'b1);
    tick();
    bus.start = 1'b0;
    wait_done(10, w);
    if (bus.done) check_result("dz_setup", e);
    tick();
    drive_ops(64'd100, 64'd7);
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("hold_q_in_run", {bus.Q2, bus.Q1}, '1);
    chk("hold_dz_in_run", {63'd0, bus.dz}, 64'd1);
    chk("busy_in_run", {63'd0, bus.busy}, 64'd1);
    repeat (24) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_q", {bus.Q2, bus.Q1}, 64'd0);
    chk("midrun_rst_r", {bus.R2, bus.R1}, 64'd0);
    chk("midrun_rst_flags", {61'd0, bus.busy, bus.done, bus.dz}, 64'd0);
    count_dones(80, nd);
    chk("midrun_rst_no_done", nd, 64'd0);
    $display("midrun_rst busy=%0d dz=%0d", bus.busy, bus.dz);

    // Reset coincident with start wins.
    drive_ops(64'd12, 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_with_start_busy", {63'd0, bus.busy}, 64'd0);
    count_dones(80, nd);
    chk("rst_with_start_no_done", nd, 64'd0);

    // Fresh division after reset completes normally.
    issue(64'd12, 64'd4, 64'd3, 64'd0, 1'b0);
    tick();
    bus.start = 1'b0;
    wait_done(80, w);
    chk("post_rst_latency", w + 1, 64'd65);
    if (bus.done) check_result("post_rst", e);
    $display("post_rst q=%h r=%h", {bus.Q2, bus.Q1}, {bus.R2, bus.R1});
    tick();

    // Back-to-back random sweep, start re-driven in each done cycle.
    d = ({$urandom, $urandom} >> $urandom_range(0, 63));
    if (d == 64'd0) d = 64'd1;
    n = ({$urandom, $urandom} >> $urandom_range(0, 63));
    issue(n, d, n / d, n % d, 1'b0);
    for (int k = 0; k < NS; k++) begin
      wait_done(70, w);
      if (!bus.done) break;
      chk("sweep_spacing", w, 64'd65);
      check_result("sweep", e);
      recon = {64'd0, bus.Q2, bus.Q1} * {64'd0, e.d} + {64'd0, bus.R2, bus.R1};
      checks++;
      if (recon !== {64'd0, e.n} || {bus.R2, bus.R1} >= e.d) begin
        errors++;
        $display("FAIL sweep_invariant n=%h d=%h got q=%h r=%h required n=q*d+r and r<d",
                 e.n, e.d, {bus.Q2, bus.Q1}, {bus.R2, bus.R1});
      end
      if (k < NS - 1) begin
        d = ({$urandom, $urandom} >> $urandom_range(0, 63));
        if (d == 64'd0) d = 64'd1;
        n = ({$urandom, $urandom} >> $urandom_range(0, 63));
        issue(n, d, n / d, n % d, 1'b0);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    $display("sweep complete, %0d results outstanding", sbq.size());
    chk("sweep_drained", sbq.size(), 64'd0);
    tick();
    chk("sweep_done_low", {63'd0, bus.done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
